uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rr_pick.sv | 37 +++
 rtl/uart_tx_arb.sv | 135 +++++++++++++
 tb/tb_uart_tx_arb.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Optional packet locking is compiled in with UART_ARB_LOCK_EN.
package uart_pkg;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_LOCK_TIMEOUT = 1023;

`ifdef UART_ARB_LOCK_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1
    } state_t;
`endif

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority selector: first set request at or after i_ptr,
// wrapping modulo N.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int  N  = DEF_NUM_REQ,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);

    logic [N-1:0]  w_rot;
    logic [IW-1:0] w_off;
    logic [IW:0]   w_sum;

    // bit 0 of w_rot is the requester sitting at i_ptr
    assign w_rot = N'({i_req, i_req} >> i_ptr);

    always_comb begin
        o_found = 1'b0;
        w_off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                o_found = 1'b1;
                w_off   = IW'(i);
            end
        end
    end

    assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_idx = (w_sum >= (IW + 1)'(N)) ?
                   IW'(w_sum - (IW + 1)'(N)) : IW'(w_sum);

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding bytes from NUM_REQ requesters to one UART.
// Define UART_ARB_LOCK_EN to keep a grant across a multi-byte packet.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int  NUM_REQ      = DEF_NUM_REQ,
    parameter int  LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    localparam int IW           = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [7:0]             tx_data,
    output logic                   tx_data_valid,
    input  logic                   tx_data_ack,
    output logic [IW-1:0]          grant_id,
    output logic                   busy
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_data;
    logic [7:0]    w_data_nxt;
    logic [IW-1:0] r_grant;
    logic [IW-1:0] w_grant_nxt;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_ptr_nxt;
    logic [IW-1:0] w_ptr_inc;
    logic [IW-1:0] w_pick;
    logic          w_found;
    logic          w_ack;

`ifdef UART_ARB_LOCK_EN
    logic [15:0]   r_timer;
    logic [15:0]   w_timer_nxt;
`else
    logic          w_unused_last;
    assign w_unused_last = ^req_last;
`endif

    uart_rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    assign w_ack     = tx_data_ack && (r_state == ST_SEND);
    assign w_ptr_inc = (r_grant == IW'(NUM_REQ - 1)) ?
                       '0 : r_grant + IW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
`ifdef UART_ARB_LOCK_EN
        w_timer_nxt = r_timer;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_grant_nxt = w_pick;
                    w_data_nxt  = req_data[8*w_pick +: 8];
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_data_ack) begin
`ifdef UART_ARB_LOCK_EN
                    // mid-packet byte: hold the grant, keep rr_ptr
                    if (!req_last[r_grant]) begin
                        w_state_nxt = ST_LOCKED;
                        w_timer_nxt = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_ptr_nxt   = w_ptr_inc;
                    end
`else
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = w_ptr_inc;
`endif
                end
            end
`ifdef UART_ARB_LOCK_EN
            ST_LOCKED: begin
                if (req_valid[r_grant]) begin
                    w_data_nxt  = req_data[8*r_grant +: 8];
                    w_state_nxt = ST_SEND;
                    w_timer_nxt = '0;
                end else if (r_timer == 16'(LOCK_TIMEOUT - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = w_ptr_inc;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + 16'd1;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_data  <= 8'h00;
            r_grant <= '0;
            r_ptr   <= '0;
`ifdef UART_ARB_LOCK_EN
            r_timer <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
`ifdef UART_ARB_LOCK_EN
            r_timer <= w_timer_nxt;
`endif
        end
    end

    assign req_ack       = w_ack ? (NUM_REQ'(1) << r_grant) : '0;
    assign tx_data       = r_data;
    assign tx_data_valid = (r_state == ST_SEND);
    assign grant_id      = r_grant;
    assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: transaction-level model,
// directed scenarios and randomized traffic.
module tb_uart_tx_arb;

    localparam int NR = 4;
    localparam int TO = 15;
`ifdef UART_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [8*NR-1:0] rd;
    logic [NR-1:0]   rv;
    logic [NR-1:0]   rl;
    logic [NR-1:0]   req_ack;
    logic [7:0]      tx_data;
    logic            tx_data_valid;
    logic            ack;
    logic [1:0]      grant_id;
    logic            busy;

    uart_tx_arb #(
        .NUM_REQ      (NR),
        .LOCK_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_data      (rd),
        .req_valid     (rv),
        .req_last      (rl),
        .req_ack       (req_ack),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ack   (ack),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    bit prev_v = 1'b0;
    int g_log[$];
    logic [8:0] q[NR][$];

    // model: 0 = no offer, 1 = offering a byte, 2 = holding a packet lock
    int         m_phase  = 0;
    int         m_ptr    = 0;
    int         m_id     = 0;
    int         m_timer  = 0;
    int         m_ack_id = -1;
    logic [7:0] m_data   = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int first_from(input int p);
        for (int k = 0; k < NR; k++) begin
            if (rv[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        int j;
        if (!rst) begin
            m_phase  = 0;
            m_ptr    = 0;
            m_id     = 0;
            m_timer  = 0;
            m_ack_id = -1;
            m_data   = 8'h00;
        end else begin
            m_ack_id = -1;
            case (m_phase)
                0: begin
                    j = first_from(m_ptr);
                    if (j >= 0) begin
                        m_id    = j;
                        m_data  = rd[8*j +: 8];
                        m_phase = 1;
                    end
                end
                1: begin
                    if (ack) begin
                        m_ack_id = m_id;
                        if (LOCK && !rl[m_id]) begin
                            m_phase = 2;
                            m_timer = 0;
                        end else begin
                            m_phase = 0;
                            m_ptr   = (m_id + 1) % NR;
                        end
                    end
                end
                default: begin
                    if (rv[m_id]) begin
                        m_data  = rd[8*m_id +: 8];
                        m_phase = 1;
                        m_timer = 0;
                    end else begin
                        m_timer++;
                        if (m_timer >= TO) begin
                            m_phase = 0;
                            m_ptr   = (m_id + 1) % NR;
                            m_timer = 0;
                        end
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        logic [NR-1:0] e_ack;
        if (chk_en) begin
            e_ack = (m_phase == 1 && ack) ? (NR'(1) << m_id) : '0;
            chk("valid", tx_data_valid, m_phase == 1);
            chk("tx_data", tx_data, m_data);
            chk("grant_id", grant_id, m_id);
            chk("busy", busy, m_phase != 0);
            chk("req_ack", req_ack, e_ack);
        end
        if (tx_data_valid && !prev_v) g_log.push_back(int'(grant_id));
        prev_v = tx_data_valid;
    end

    task automatic apply_reqs();
        for (int i = 0; i < NR; i++) begin
            if (q[i].size() > 0) begin
                rv[i]        = 1'b1;
                rd[8*i +: 8] = q[i][0][7:0];
                rl[i]        = q[i][0][8];
            end else begin
                rv[i]        = 1'b0;
                rd[8*i +: 8] = 8'h00;
                rl[i]        = 1'b0;
            end
        end
    endtask

    task automatic pop_acked();
        if (m_ack_id >= 0 && q[m_ack_id].size() > 0)
            void'(q[m_ack_id].pop_front());
    endtask

    task automatic step(input bit a);
        @(posedge clk);
        #1;
        pop_acked();
        apply_reqs();
        ack = a;
    endtask

    task automatic rand_step();
        @(posedge clk);
        #1;
        pop_acked();
        for (int i = 0; i < NR; i++) begin
            if ($urandom_range(7) == 0 && q[i].size() < 4)
                q[i].push_back({1'($urandom_range(1)), 8'($urandom)});
        end
        apply_reqs();
        ack = 1'($urandom_range(1));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < NR; i++) q[i].delete();
        apply_reqs();
        ack = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int lk;
        rst = 1'b0;
        ack = 1'b1;
        rv  = '1;
        rd  = 32'hDEADBEEF;
        rl  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_valid", tx_data_valid, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", req_ack, 0);
        chk_en = 1'b1;

        // single requester, latency and same-cycle ack
        do_reset();
        q[2].push_back({1'b1, 8'hA5});
        step(0);
        @(negedge clk);
        chk("r32_pre_valid", tx_data_valid, 0);
        step(0);
        @(negedge clk);
        chk("r32_valid", tx_data_valid, 1);
        chk("r32_data", tx_data, 8'hA5);
        chk("r32_grant", grant_id, 2);
        step(1);
        @(negedge clk);
        chk("r32_ack", req_ack, 4'b0100);
        step(0);
        @(negedge clk);
        chk("r32_drop", tx_data_valid, 0);
        chk("r32_ack_off", req_ack, 0);

        // all four requesters valid, round-robin order
        do_reset();
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < 3; k++)
                q[i].push_back({1'b1, 8'(16 * i + k)});
        g_log.delete();
        for (int c = 0; c < 40 && g_log.size() < 8; c++) step(1);
        chk("r33_cnt", g_log.size() >= 8, 1);
        for (int k = 0; k < 8; k++)
            if (k < g_log.size())
                chk($sformatf("r33_g%0d", k), g_log[k], k % 4);

        // data changes during an offer are ignored
        do_reset();
        q[1].push_back({1'b1, 8'h3C});
        step(0);
        step(0);
        @(negedge clk);
        chk("r34_data", tx_data, 8'h3C);
        q[1][0] = {1'b1, 8'hC3};
        step(0);
        @(negedge clk);
        chk("r34_hold", tx_data, 8'h3C);
        step(1);
        @(negedge clk);
        chk("r34_hold2", tx_data, 8'h3C);
        chk("r34_ack", req_ack, 4'b0010);
        step(0);

        // async reset mid-offer, then restart from rr_ptr 0
        do_reset();
        q[1].push_back({1'b1, 8'h11});
        step(0);
        step(0);
        step(1);
        step(0);
        q[0].push_back({1'b1, 8'h22});
        q[2].push_back({1'b1, 8'h33});
        step(0);
        step(0);
        @(negedge clk);
        chk("r35_grant2", grant_id, 2);
        chk("r35_valid", tx_data_valid, 1);
        step(1);
        #2;
        rst = 1'b0;
        #1;
        chk("r35_async_valid", tx_data_valid, 0);
        chk("r35_async_ack", req_ack, 0);
        chk("r35_async_busy", busy, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        ack = 1'b0;
        g_log.delete();
        for (int c = 0; c < 6 && g_log.size() < 1; c++) step(0);
        chk("r35_regrant", g_log.size() >= 1, 1);
        if (g_log.size() >= 1) chk("r35_first", g_log[0], 0);
        chk("r35_q2_kept", q[2].size(), 1);

`ifdef UART_ARB_LOCK_EN
        // packet lock holds the grant across three bytes
        do_reset();
        q[0].push_back({1'b0, 8'h01});
        q[0].push_back({1'b0, 8'h02});
        q[0].push_back({1'b1, 8'h03});
        q[3].push_back({1'b1, 8'h04});
        g_log.delete();
        for (int c = 0; c < 40 && g_log.size() < 4; c++) step(1);
        chk("r36_cnt", g_log.size() >= 4, 1);
        for (int k = 0; k < 4; k++)
            if (k < g_log.size())
                chk($sformatf("r36_g%0d", k), g_log[k], (k == 3) ? 3 : 0);

        // stalled packet times out after TO cycles
        do_reset();
        q[0].push_back({1'b0, 8'h55});
        q[3].push_back({1'b1, 8'h66});
        g_log.delete();
        lk = 0;
        for (int c = 0; c < 80 && g_log.size() < 2; c++) begin
            step(1);
            @(negedge clk);
            if (busy && !tx_data_valid) lk++;
        end
        chk("r37_locked_cycles", lk, TO);
        chk("r37_cnt", g_log.size() >= 2, 1);
        if (g_log.size() >= 2) chk("r37_next", g_log[1], 3);
`endif

        // randomized traffic against the model
        do_reset();
        repeat (3000) rand_step();
        repeat (200) step(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
